// File: rtl/honzales_pkg.sv
// Shared definitions for the honzales run controller: FSM encoding,
// register byte offsets and CTRL/STATUS bit positions.
package honzales_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRERST  = 2'd1,
        ST_RUN     = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    // Register byte offsets within the 256-byte window
    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_CYCLES = 8'h04;
    localparam logic [7:0] OFF_STATUS = 8'h08;
    localparam logic [7:0] OFF_RESULT = 8'h0C;
    localparam logic [7:0] OFF_REMAIN = 8'h10;

    // CTRL bit positions
    localparam int CTRL_START_BIT    = 0;
    localparam int CTRL_ABORT_BIT    = 1;
    localparam int CTRL_IRQ_EN_BIT   = 2;
    localparam int CTRL_IN_LEVEL_BIT = 3;

    // STATUS bit positions (state occupies bits 1:0)
    localparam int STAT_BUSY_BIT    = 2;
    localparam int STAT_DONE_BIT    = 3;
    localparam int STAT_ABORTED_BIT = 4;

    // Value of the PRERST cycle counter on the last core-reset cycle
    localparam logic PRERST_LAST = 1'b1;

endpackage

// File: rtl/wb_regs_slave.sv
// Wishbone register slave: address decode, single-cycle ack, register
// storage for CTRL/CYCLES and the read mux. Command bits leave as pulses.
module wb_regs_slave
    import honzales_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic             i_clk,
    input  logic             i_srst,
    input  logic             i_wbs_stb,
    input  logic             i_wbs_cyc,
    input  logic             i_wbs_we,
    input  logic [3:0]       i_wbs_sel,
    input  logic [31:0]      i_wbs_dat,
    input  logic [31:0]      i_wbs_adr,
    output logic             o_wbs_ack,
    output logic [31:0]      o_wbs_dat,
    input  state_t           i_state,
    input  logic             i_done,
    input  logic             i_aborted,
    input  logic [7:0]       i_result,
    input  logic [CNT_W-1:0] i_remain,
    output logic             o_start,
    output logic             o_abort,
    output logic             o_done_clr,
    output logic             o_aborted_clr,
    output logic             o_irq_en,
    output logic             o_in_level,
    output logic [CNT_W-1:0] o_cycles
);

    logic             r_ack;
    logic [31:0]      r_dat;
    logic             r_irq_en;
    logic             r_in_level;
    logic [CNT_W-1:0] r_cycles;

    logic             w_valid;
    logic             w_wr;
    logic [7:0]       w_off;
    logic             w_wr_ctrl;
    logic             w_wr_cycles;
    logic             w_wr_status;
    logic [31:0]      w_rdata;
    logic [CNT_W-1:0] w_cycles_next;
    logic             w_unused_ok;

    assign w_valid = i_wbs_cyc & i_wbs_stb & (i_wbs_adr[31:8] == BASE_ADDR[31:8]);
    assign w_off   = i_wbs_adr[7:0];
    // Writes land on the ack cycle, while the master still holds the request
    assign w_wr    = r_ack & w_valid & i_wbs_we;

    // CTRL and STATUS live entirely in byte lane 0
    assign w_wr_ctrl   = w_wr & (w_off == OFF_CTRL) & i_wbs_sel[0];
    assign w_wr_status = w_wr & (w_off == OFF_STATUS) & i_wbs_sel[0];
    assign w_wr_cycles = w_wr & (w_off == OFF_CYCLES);

    assign o_start       = w_wr_ctrl & i_wbs_dat[CTRL_START_BIT];
    assign o_abort       = w_wr_ctrl & i_wbs_dat[CTRL_ABORT_BIT];
    assign o_done_clr    = w_wr_status & i_wbs_dat[STAT_DONE_BIT];
    assign o_aborted_clr = w_wr_status & i_wbs_dat[STAT_ABORTED_BIT];

    // CYCLES byte-lane merge: each bit follows the select of its byte
    generate
        for (genvar gi = 0; gi < CNT_W; gi++) begin : g_cyc_bit
            assign w_cycles_next[gi] = (w_wr_cycles & i_wbs_sel[gi/8]) ?
                                       i_wbs_dat[gi] : r_cycles[gi];
        end
    endgenerate

    // Read mux; unmapped offsets return zero
    always_comb begin
        w_rdata = '0;
        case (w_off)
            OFF_CTRL: begin
                w_rdata[CTRL_IRQ_EN_BIT]   = r_irq_en;
                w_rdata[CTRL_IN_LEVEL_BIT] = r_in_level;
            end
            OFF_CYCLES: w_rdata[CNT_W-1:0] = r_cycles;
            OFF_STATUS: begin
                w_rdata[1:0]             = i_state;
                w_rdata[STAT_BUSY_BIT]    = (i_state != ST_IDLE);
                w_rdata[STAT_DONE_BIT]    = i_done;
                w_rdata[STAT_ABORTED_BIT] = i_aborted;
            end
            OFF_RESULT: w_rdata[7:0] = i_result;
            OFF_REMAIN: w_rdata[CNT_W-1:0] = i_remain;
            default:    w_rdata = '0;
        endcase
    end

    // Ack/read-data pipeline and CTRL/CYCLES storage
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_ack      <= 1'b0;
            r_dat      <= '0;
            r_irq_en   <= 1'b0;
            r_in_level <= 1'b0;
            r_cycles   <= '0;
        end else begin
            r_ack    <= w_valid & ~r_ack;
            r_dat    <= (w_valid & ~r_ack) ? w_rdata : 32'h0;
            r_cycles <= w_cycles_next;
            if (w_wr_ctrl) begin
                r_irq_en   <= i_wbs_dat[CTRL_IRQ_EN_BIT];
                r_in_level <= i_wbs_dat[CTRL_IN_LEVEL_BIT];
            end
        end
    end

    // Data bits beyond the implemented fields are intentionally ignored
    assign w_unused_ok = ^{i_wbs_dat, i_wbs_sel};

    assign o_wbs_ack  = r_ack;
    assign o_wbs_dat  = r_dat;
    assign o_irq_en   = r_irq_en;
    assign o_in_level = r_in_level;
    assign o_cycles   = r_cycles;

endmodule

// File: rtl/honzales_run_ctrl.sv
// Run controller for an 8-bit sequenced core: pulses core reset for two
// cycles, enables the core for CYCLES steps, then captures its output.
module honzales_run_ctrl
    import honzales_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        la_start,
    output logic        core_rst,
    output logic        core_en,
    output logic        core_in,
    input  logic [7:0]  core_out,
    output logic        irq
);

    state_t           r_state, w_state_next;
    logic [CNT_W-1:0] r_remain, w_remain_next;
    logic [7:0]       r_result, w_result_next;
    logic             r_done, w_done_next;
    logic             r_aborted, w_aborted_next;
    logic             r_pre_cnt, w_pre_cnt_next;
    logic             r_la_q;
    logic             r_core_in;

    logic             w_start_wr;
    logic             w_abort_wr;
    logic             w_done_clr;
    logic             w_aborted_clr;
    logic             w_irq_en;
    logic             w_in_level;
    logic [CNT_W-1:0] w_cycles;
    logic             w_la_rise;
    logic             w_start;
    logic             w_core_en;
    logic             w_core_rst;

    wb_regs_slave #(
        .BASE_ADDR (BASE_ADDR),
        .CNT_W     (CNT_W)
    ) u_regs (
        .i_clk         (wb_clk_i),
        .i_srst        (wb_rst_i),
        .i_wbs_stb     (wbs_stb_i),
        .i_wbs_cyc     (wbs_cyc_i),
        .i_wbs_we      (wbs_we_i),
        .i_wbs_sel     (wbs_sel_i),
        .i_wbs_dat     (wbs_dat_i),
        .i_wbs_adr     (wbs_adr_i),
        .o_wbs_ack     (wbs_ack_o),
        .o_wbs_dat     (wbs_dat_o),
        .i_state       (r_state),
        .i_done        (r_done),
        .i_aborted     (r_aborted),
        .i_result      (r_result),
        .i_remain      (r_remain),
        .o_start       (w_start_wr),
        .o_abort       (w_abort_wr),
        .o_done_clr    (w_done_clr),
        .o_aborted_clr (w_aborted_clr),
        .o_irq_en      (w_irq_en),
        .o_in_level    (w_in_level),
        .o_cycles      (w_cycles)
    );

    // A START write and an la_start edge together still mean one run;
    // an ABORT in the same write suppresses the start.
    assign w_la_rise = la_start & ~r_la_q;
    assign w_start   = (w_start_wr | w_la_rise) & ~w_abort_wr;

    // State and datapath registers
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= ST_IDLE;
            r_remain  <= '0;
            r_result  <= '0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_pre_cnt <= 1'b0;
            r_la_q    <= 1'b1;
            r_core_in <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_remain  <= w_remain_next;
            r_result  <= w_result_next;
            r_done    <= w_done_next;
            r_aborted <= w_aborted_next;
            r_pre_cnt <= w_pre_cnt_next;
            r_la_q    <= la_start;
            r_core_in <= w_in_level;
        end
    end

    // Next-state, datapath next values and core control outputs
    always_comb begin
        w_state_next   = r_state;
        w_remain_next  = r_remain;
        w_result_next  = r_result;
        w_done_next    = r_done & ~w_done_clr;
        w_aborted_next = r_aborted & ~w_aborted_clr;
        w_pre_cnt_next = r_pre_cnt;
        w_core_en      = 1'b0;
        w_core_rst     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_next   = ST_PRERST;
                    w_remain_next  = w_cycles;
                    w_pre_cnt_next = 1'b0;
                    w_done_next    = 1'b0;
                    w_aborted_next = 1'b0;
                end
            end
            ST_PRERST: begin
                w_core_rst = 1'b1;
                if (r_pre_cnt == PRERST_LAST) begin
                    w_pre_cnt_next = 1'b0;
                    // REMAIN holds the length latched at start, immune to later CYCLES writes
                    w_state_next   = (r_remain == '0) ? ST_CAPTURE : ST_RUN;
                end else begin
                    w_pre_cnt_next = PRERST_LAST;
                end
            end
            ST_RUN: begin
                w_core_en     = 1'b1;
                w_remain_next = r_remain - CNT_W'(1);
                if (r_remain <= CNT_W'(1)) begin
                    w_state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                w_result_next = core_out;
                w_done_next   = 1'b1;
                w_state_next  = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase

        // Abort overrides everything except in IDLE; RESULT and DONE stay put
        if (w_abort_wr && (r_state != ST_IDLE)) begin
            w_state_next   = ST_IDLE;
            w_remain_next  = r_remain;
            w_result_next  = r_result;
            w_done_next    = r_done & ~w_done_clr;
            w_aborted_next = 1'b1;
            w_pre_cnt_next = 1'b0;
        end
    end

    assign core_en  = w_core_en;
    assign core_rst = w_core_rst | wb_rst_i;
    assign core_in  = r_core_in;
    assign irq      = w_irq_en & r_done;

endmodule

// File: tb/tb_honzales_run_ctrl.sv
// Directed bench for honzales_run_ctrl: Wishbone register access, run
// sequencing, abort, busy behaviour, irq and reset-during-run.
module tb_honzales_run_ctrl;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [7:0]  O_CTRL = 8'h00, O_CYC = 8'h04, O_STAT = 8'h08,
                            O_RES = 8'h0C, O_REM = 8'h10;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i, wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        la_start;
    logic        core_rst, core_en, core_in;
    logic [7:0]  core_out;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;
    int en_cnt = 0;
    int rst_cnt = 0;

    honzales_run_ctrl #(.BASE_ADDR(BASE), .CNT_W(16)) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .la_start  (la_start),
        .core_rst  (core_rst),
        .core_en   (core_en),
        .core_in   (core_in),
        .core_out  (core_out),
        .irq       (irq)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Count core enable and (non-reset) core reset cycles, sampled mid-cycle
    always @(negedge wb_clk_i) begin
        if (core_en) en_cnt = en_cnt + 1;
        if (core_rst && !wb_rst_i) rst_cnt = rst_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                           input logic [3:0] sel, output logic [31:0] rdat);
        bit got_ack;
        int n;
        @(negedge wb_clk_i);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr; wbs_dat_i = wdat; wbs_sel_i = sel;
        got_ack = 1'b0;
        n = 0;
        while (!got_ack && n < 8) begin
            @(negedge wb_clk_i);
            n++;
            if (wbs_ack_o) got_ack = 1'b1;
        end
        rdat = wbs_dat_o;
        check("ack_seen", 32'(got_ack), 32'd1);
        @(posedge wb_clk_i);
        #1;
        check("ack_one_cycle", 32'(wbs_ack_o), 32'd0);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        $display("wb %s adr=%h wdat=%h sel=%h rdat=%h", we ? "wr" : "rd", adr, wdat, sel, rdat);
    endtask

    task automatic wb_wr(input logic [7:0] off, input logic [31:0] d, input logic [3:0] sel);
        logic [31:0] dummy;
        wb_xfer(1'b1, BASE | {24'h0, off}, d, sel, dummy);
    endtask

    task automatic wb_rd(input logic [7:0] off, output logic [31:0] d);
        wb_xfer(1'b0, BASE | {24'h0, off}, 32'h0, 4'hF, d);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int en_base, rst_base, en_snap, acks, k;

        wb_rst_i = 1'b1; wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = 4'h0; wbs_dat_i = '0; wbs_adr_i = '0;
        la_start = 1'b1; core_out = 8'hA5;

        // ---- reset values; la_start held high through release ----
        repeat (3) @(negedge wb_clk_i);
        check("rst_core_rst", 32'(core_rst), 32'd1);
        check("rst_core_en", 32'(core_en), 32'd0);
        check("rst_ack", 32'(wbs_ack_o), 32'd0);
        check("rst_dat", wbs_dat_o, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_core_in", 32'(core_in), 32'd0);
        wb_rst_i = 1'b0;
        repeat (4) @(negedge wb_clk_i);
        check("la_high_no_start_rst", 32'(core_rst), 32'd0);
        wb_rd(O_STAT, rd); check("la_high_no_start_status", rd, 32'h0);
        la_start = 1'b0;
        wb_rd(O_CYC, rd);  check("rst_cycles", rd, 32'h0);
        wb_rd(O_RES, rd);  check("rst_result", rd, 32'h0);
        wb_rd(O_REM, rd);  check("rst_remain", rd, 32'h0);
        wb_rd(O_CTRL, rd); check("rst_ctrl", rd, 32'h0);

        // ---- CYCLES=5 run ----
        wb_wr(O_CYC, 32'd5, 4'hF);
        en_base = en_cnt; rst_base = rst_cnt;
        wb_wr(O_CTRL, 32'h1, 4'h1);
        repeat (12) @(negedge wb_clk_i);
        check("run5_en_cycles", 32'(en_cnt - en_base), 32'd5);
        check("run5_rst_cycles", 32'(rst_cnt - rst_base), 32'd2);
        wb_rd(O_STAT, rd); check("run5_status", rd, 32'h08);
        wb_rd(O_RES, rd);  check("run5_result", rd, 32'hA5);
        wb_rd(O_REM, rd);  check("run5_remain", rd, 32'h0);

        // ---- CYCLES=0 run with IRQ_EN: DONE three edges after the write ----
        core_out = 8'h3C;
        wb_wr(O_CYC, 32'd0, 4'hF);
        en_base = en_cnt; rst_base = rst_cnt;
        wb_wr(O_CTRL, 32'h5, 4'h1);
        repeat (2) @(posedge wb_clk_i);
        #1 check("run0_irq_early", 32'(irq), 32'd0);
        @(posedge wb_clk_i);
        #1 check("run0_irq_done", 32'(irq), 32'd1);
        check("run0_en_cycles", 32'(en_cnt - en_base), 32'd0);
        check("run0_rst_cycles", 32'(rst_cnt - rst_base), 32'd2);
        wb_rd(O_RES, rd); check("run0_result", rd, 32'h3C);
        wb_wr(O_STAT, 32'h08, 4'h1);
        check("w1c_irq_clear", 32'(irq), 32'd0);
        wb_rd(O_STAT, rd); check("w1c_status", rd, 32'h0);

        // ---- IN_LEVEL to core_in is registered ----
        wb_wr(O_CTRL, 32'h8, 4'h1);
        check("core_in_lag", 32'(core_in), 32'd0);
        @(posedge wb_clk_i);
        #1 check("core_in_set", 32'(core_in), 32'd1);
        wb_rd(O_CTRL, rd); check("ctrl_readback", rd, 32'h8);
        wb_wr(O_CTRL, 32'h0, 4'h1);

        // ---- CYCLES=100, abort at run cycle ~10 ----
        core_out = 8'h11;
        wb_wr(O_CYC, 32'd100, 4'hF);
        en_base = en_cnt;
        wb_wr(O_CTRL, 32'h1, 4'h1);
        k = 0;
        while ((en_cnt - en_base) < 10 && k < 50) begin
            @(negedge wb_clk_i);
            k++;
        end
        check("abort_reached_run", 32'(k < 50), 32'd1);
        wb_wr(O_CTRL, 32'h2, 4'h1);
        check("abort_core_en", 32'(core_en), 32'd0);
        check("abort_core_rst", 32'(core_rst), 32'd0);
        en_snap = en_cnt;
        repeat (5) @(negedge wb_clk_i);
        check("abort_en_stays_low", 32'(en_cnt - en_snap), 32'd0);
        wb_rd(O_STAT, rd); check("abort_status", rd, 32'h10);
        wb_rd(O_RES, rd);  check("abort_result_kept", rd, 32'h3C);

        // ---- START/la_start while busy ignored; CYCLES write while busy ----
        core_out = 8'h77;
        en_base = en_cnt;
        wb_wr(O_CTRL, 32'h1, 4'h1);
        repeat (20) @(negedge wb_clk_i);
        wb_wr(O_CTRL, 32'h1, 4'h1);
        repeat (10) @(negedge wb_clk_i);
        la_start = 1'b1;
        repeat (3) @(negedge wb_clk_i);
        la_start = 1'b0;
        wb_wr(O_CYC, 32'd7, 4'hF);
        repeat (120) @(negedge wb_clk_i);
        check("busy_run_len", 32'(en_cnt - en_base), 32'd100);
        wb_rd(O_STAT, rd); check("busy_status", rd, 32'h08);
        wb_rd(O_RES, rd);  check("busy_result", rd, 32'h77);
        wb_rd(O_CYC, rd);  check("busy_cycles_reg", rd, 32'd7);

        // ---- la_start rising edge starts a run from IDLE ----
        core_out = 8'h42;
        en_base = en_cnt;
        @(negedge wb_clk_i);
        la_start = 1'b1;
        repeat (3) @(negedge wb_clk_i);
        la_start = 1'b0;
        repeat (15) @(negedge wb_clk_i);
        check("la_run_len", 32'(en_cnt - en_base), 32'd7);
        wb_rd(O_RES, rd); check("la_result", rd, 32'h42);

        // ---- START and ABORT together: no run ----
        en_base = en_cnt;
        wb_wr(O_CTRL, 32'h3, 4'h1);
        repeat (5) @(negedge wb_clk_i);
        check("start_abort_no_run", 32'(en_cnt - en_base), 32'd0);
        wb_rd(O_STAT, rd); check("start_abort_status", rd, 32'h08);

        // ---- reset during RUN ----
        wb_wr(O_CYC, 32'd100, 4'hF);
        wb_wr(O_CTRL, 32'h1, 4'h1);
        repeat (10) @(negedge wb_clk_i);
        check("pre_reset_running", 32'(core_en), 32'd1);
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i);
        #1;
        check("midrst_core_en", 32'(core_en), 32'd0);
        check("midrst_core_rst", 32'(core_rst), 32'd1);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        wb_rd(O_STAT, rd); check("midrst_status", rd, 32'h0);
        wb_rd(O_RES, rd);  check("midrst_result", rd, 32'h0);

        // ---- CYCLES byte lanes, unmapped offset, address miss ----
        wb_wr(O_CYC, 32'h0000_ABCD, 4'b0001);
        wb_rd(O_CYC, rd); check("lane0", rd, 32'h0000_00CD);
        wb_wr(O_CYC, 32'h1234_5678, 4'b0010);
        wb_rd(O_CYC, rd); check("lane1", rd, 32'h0000_56CD);
        wb_wr(O_CYC, 32'hFFFF_FFFF, 4'b1100);
        wb_rd(O_CYC, rd); check("lane_upper_ignored", rd, 32'h0000_56CD);
        wb_wr(8'h14, 32'hFFFF_FFFF, 4'hF);
        wb_rd(8'h14, rd); check("unmapped_read", rd, 32'h0);
        wb_rd(O_CYC, rd); check("unmapped_no_effect", rd, 32'h0000_56CD);

        @(negedge wb_clk_i);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = 32'h4000_0004; wbs_dat_i = 32'h1; wbs_sel_i = 4'hF;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge wb_clk_i);
            if (wbs_ack_o) acks++;
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        check("miss_no_ack", 32'(acks), 32'd0);
        wb_rd(O_CYC, rd); check("miss_no_write", rd, 32'h0000_56CD);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/honzales_run_ctrl.md
HONZALES_RUN_CTRL -- requirements
Module: honzales_run_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, Wishbone base address; the block decodes wbs_adr_i[31:8] against BASE_ADDR[31:8].
REQ-002 SHALL have parameter CNT_W, default 16, run-length counter width (1..32).
REQ-003 SHALL have port wb_clk_i, input, 1, the single clock; all logic is synchronous to its rising edge.
REQ-004 SHALL have port wb_rst_i, input, 1, reset: synchronous, active-high.
REQ-005 SHALL have Wishbone slave ports wbs_stb_i, wbs_cyc_i, wbs_we_i (in, 1), wbs_sel_i (in, 4), wbs_dat_i and wbs_adr_i (in, 32), wbs_ack_o (out, 1) and wbs_dat_o (out, 32).
REQ-006 SHALL have port la_start, input, 1, logic-analyzer run trigger, rising-edge sensitive.
REQ-007 SHALL have ports core_rst (out, 1) and core_en (out, 1), the reset and step enable of the sequenced 8-bit core.
REQ-008 SHALL have ports core_in (out, 1), the core serial input level, and core_out (in, 8), the core output.
REQ-009 SHALL have port irq, output, 1, level interrupt.

Function
REQ-010 Register map (byte offsets), with all other offsets reading 0 and ignoring writes:
- 0x00 CTRL: b0 START, write-1 pulse, reads 0; b1 ABORT, write-1 pulse, reads 0; b2 IRQ_EN; b3 IN_LEVEL.
- 0x04 CYCLES[CNT_W-1:0]: byte-lane writes per wbs_sel_i.
- 0x08 STATUS: b1:0 state; b2 BUSY; b3 DONE, W1C; b4 ABORTED, W1C.
- 0x0C RESULT[7:0]: read-only.
- 0x10 REMAIN[CNT_W-1:0]: read-only live down-counter.
REQ-011 Wishbone handshake:
- Access valid = cyc & stb & address hit.
- wbs_ack_o asserts exactly one cycle after valid is first seen and lasts one cycle.
- Ack is not asserted in the cycle following an ack.
- Writes take effect on the ack cycle; read data is valid on the ack cycle.
- No ack is generated for a miss.
REQ-012 FSM states: IDLE=0, PRERST=1, RUN=2, CAPTURE=3.
REQ-013 IDLE -> PRERST on a START write or an la_start rising edge. Both events in the same cycle start a single run.
REQ-014 PRERST:
- Holds core_rst=1 for exactly 2 cycles.
- Loads REMAIN with CYCLES on entry.
- Clears DONE and ABORTED.
- Then goes to RUN, or to CAPTURE if CYCLES==0.
REQ-015 RUN:
- core_en=1 each cycle and REMAIN decrements by 1 each cycle.
- When REMAIN==1 and core_en=1, next state is CAPTURE; the core therefore receives exactly CYCLES enable cycles.
REQ-016 CAPTURE:
- RESULT<=core_out; DONE<=1.
- Next state is IDLE; core_en=0.
REQ-017 An ABORT write in any state other than IDLE forces IDLE next cycle, sets ABORTED, leaves RESULT and DONE unchanged, and drops core_en and core_rst.
REQ-018 START and ABORT in the same write: ABORT wins, no run starts.
REQ-019 START or la_start while BUSY (state!=IDLE) SHALL be ignored; a CYCLES write while BUSY SHALL update the register but not REMAIN.
REQ-020 core_in = IN_LEVEL, registered.
REQ-021 irq = IRQ_EN & DONE.
REQ-022 BUSY = (state != IDLE).

Reset
REQ-023 On wb_rst_i=1 at a clock edge, the block SHALL return to these values:
- State IDLE.
- CTRL, CYCLES, REMAIN, RESULT, DONE and ABORTED all 0.
- wbs_ack_o=0, wbs_dat_o=0, core_en=0, core_in=0, irq=0.
REQ-024 core_rst SHALL be 1 while wb_rst_i=1, and SHALL be 0 in IDLE otherwise.
REQ-025 Reset asserted mid-run SHALL abort without setting ABORTED.
REQ-026 The la_start edge detector SHALL reset to 1, so that a high level at reset release is not treated as a rising edge.

Structure
REQ-027 The state encoding, register offsets and CTRL/STATUS bit positions SHALL be defined in shared package honzales_pkg.
REQ-028 The Wishbone register file SHALL be a sub-module, wb_regs_slave, holding decode, ack generation and read mux; the FSM SHALL remain in the top level.

Verification
REQ-029 CYCLES=5, START:
- core_rst high for 2 cycles, then core_en high for exactly 5 cycles.
- RESULT=core_out at CAPTURE; DONE=1; REMAIN=0.
REQ-030 CYCLES=0, START: no core_en cycles; DONE=1 three cycles after the write ack.
REQ-031 CYCLES=100, ABORT written at run cycle 10: core_en low next cycle, ABORTED=1, DONE=0, RESULT unchanged.
REQ-032 START while BUSY, and la_start rising during a run: the run length stays 100, with no restart.
REQ-033 IRQ_EN=1, run completes: irq=1; writing STATUS b3=1 clears irq the cycle after ack.
REQ-034 wb_rst_i asserted during RUN: next cycle state=IDLE, core_en=0, core_rst=1, ABORTED=0; reading 0x0C after release returns 0.
